// File: rtl/io_pkg.sv
// Shared IO block definitions: requester count, console index width, FSM states.
package io_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StAck    = 2'd2
  } io_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first high req bit starting at (last_grant + 1) mod 4.
module rr_pick4
  import io_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            last_grant,
  output logic            valid,
  output idx_t            idx
);

  idx_t cand;

  // Scan the four positions in rotating order; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + idx_t'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates four console CPUs onto a single IO bus, one transaction at a time.
module io_bus_arbiter
  import io_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned NREQ        = io_pkg::NREQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*16-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_din,
  input  logic [NREQ-1:0]    req_we,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ*8-1:0]  rdata,
  output logic [18:0]        io_address,
  output logic [7:0]         io_din,
  output logic               io_we,
  input  logic [7:0]         io_dout,
  output logic               busy
);

  io_state_e  state;
  idx_t       grant;
  idx_t       last_grant;
  logic       we_lat;
  logic [3:0] cnt;
  logic       pick_valid;
  idx_t       pick_idx;

  rr_pick4 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Busy is a pure decode of the state register.
  assign busy = (state != StIdle);

  // Arbitration FSM with registered bus outputs, ack strobes and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      grant      <= '0;
      last_grant <= idx_t'(3);
      we_lat     <= 1'b0;
      cnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      io_address <= '0;
      io_din     <= '0;
      io_we      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          ack <= '0;
          if (pick_valid) begin
            state      <= StAccess;
            grant      <= pick_idx;
            last_grant <= pick_idx;
            we_lat     <= req_we[pick_idx];
            cnt        <= 4'(WAIT_STATES);
            io_address <= {1'b0, pick_idx, req_addr[{pick_idx, 4'b0000} +: 16]};
            io_din     <= req_din[{pick_idx, 3'b000} +: 8];
            // With no wait states the first ACCESS cycle is also the last.
            io_we      <= (WAIT_STATES == 0) ? req_we[pick_idx] : 1'b0;
          end
        end
        StAccess: begin
          if (cnt == 4'd0) begin
            state       <= StAck;
            ack[grant]  <= 1'b1;
            io_address  <= '0;
            io_din      <= '0;
            io_we       <= 1'b0;
            if (!we_lat) begin
              rdata[{grant, 3'b000} +: 8] <= io_dout;
            end
          end else begin
            cnt   <= cnt - 4'd1;
            // Strobe only on the cycle that will be the final one.
            io_we <= (cnt == 4'd1) && we_lat;
          end
        end
        StAck: begin
          ack   <= '0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench: one arbiter with no wait states, one with three.
module tb_io_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: WAIT_STATES = 0
  logic        rst_a;
  logic [3:0]  req_a, we_a, ack_a;
  logic [63:0] addr_a;
  logic [31:0] din_a, rdata_a;
  logic [18:0] ioa_a;
  logic [7:0]  iodin_a, iodout_a;
  logic        iowe_a, busy_a;

  // Instance b: WAIT_STATES = 3
  logic        rst_b;
  logic [3:0]  req_b, we_b, ack_b;
  logic [63:0] addr_b;
  logic [31:0] din_b, rdata_b;
  logic [18:0] ioa_b;
  logic [7:0]  iodin_b, iodout_b;
  logic        iowe_b, busy_b;

  io_bus_arbiter #(.WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .req_addr(addr_a), .req_din(din_a),
    .req_we(we_a), .ack(ack_a), .rdata(rdata_a), .io_address(ioa_a), .io_din(iodin_a),
    .io_we(iowe_a), .io_dout(iodout_a), .busy(busy_a)
  );

  io_bus_arbiter #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .req_addr(addr_b), .req_din(din_b),
    .req_we(we_b), .ack(ack_b), .rdata(rdata_b), .io_address(ioa_b), .io_din(iodin_b),
    .io_we(iowe_b), .io_dout(iodout_b), .busy(busy_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, "_ioa"}, 64'(ioa_a), 64'h0);
    check({tag, "_iodin"}, 64'(iodin_a), 64'h0);
    check({tag, "_iowe"}, 64'(iowe_a), 64'h0);
    check({tag, "_ack"}, 64'(ack_a), 64'h0);
    check({tag, "_busy"}, 64'(busy_a), 64'h0);
  endtask

  task automatic check_b_idle(input string tag);
    check({tag, "_ioa"}, 64'(ioa_b), 64'h0);
    check({tag, "_iodin"}, 64'(iodin_b), 64'h0);
    check({tag, "_iowe"}, 64'(iowe_b), 64'h0);
    check({tag, "_ack"}, 64'(ack_b), 64'h0);
    check({tag, "_busy"}, 64'(busy_b), 64'h0);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b0; req_a = '0; we_a = '0; addr_a = '0; din_a = '0; iodout_a = '0;
    rst_b = 1'b0; req_b = '0; we_b = '0; addr_b = '0; din_b = '0; iodout_b = '0;
    tick();
    check_a_idle("rst_a");
    check("rst_a_rdata", 64'(rdata_a), 64'h0);
    check_b_idle("rst_b");
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Single read, no wait states, requester 2.
    req_a = 4'b0100; addr_a[32 +: 16] = 16'hB001; iodout_a = 8'h5A;
    tick();
    check("rd_ioa", 64'(ioa_a), 64'h2B001);
    check("rd_busy", 64'(busy_a), 64'h1);
    check("rd_iowe", 64'(iowe_a), 64'h0);
    check("rd_ack_early", 64'(ack_a), 64'h0);
    tick();
    check("rd_ack", 64'(ack_a), 64'b0100);
    check("rd_ioa_after", 64'(ioa_a), 64'h0);
    check("rd_rdata", 64'(rdata_a), 64'h005A_0000);
    req_a = '0;
    tick();
    check_a_idle("rd_done");

    // Reset clears captured read data; then all four request together.
    reset_a();
    check("rst2_rdata", 64'(rdata_a), 64'h0);
    for (int i = 0; i < 4; i++) addr_a[i*16 +: 16] = 16'hA000 + 16'(i);
    req_a = 4'hF;
    for (int k = 0; k < 5; k++) begin
      automatic int g = k % 4;
      iodout_a = 8'h30 + 8'(k);
      tick();
      check("rr4_ioa", 64'(ioa_a), 64'({1'b0, 2'(g), 16'hA000 + 16'(g)}));
      tick();
      check("rr4_ack", 64'(ack_a), 64'(4'b0001 << g));
      check("rr4_rdata", 64'(rdata_a[g*8 +: 8]), 64'(8'h30 + 8'(k)));
      tick();
      check("rr4_ack_clr", 64'(ack_a), 64'h0);
    end
    req_a = '0;
    tick();

    // Round-robin skip: last grant 1, then req = 1001 -> 3 then 0.
    reset_a();
    req_a = 4'b0010;
    tick(); tick();
    check("skip_pre_ack", 64'(ack_a), 64'b0010);
    req_a = 4'b1001;
    tick();
    tick();
    check("skip_g3", 64'(ioa_a[17:16]), 64'h3);
    tick();
    check("skip_ack3", 64'(ack_a), 64'b1000);
    req_a = 4'b0001;
    tick();
    tick();
    check("skip_g0", 64'(ioa_a[17:16]), 64'h0);
    tick();
    check("skip_ack0", 64'(ack_a), 64'b0001);

    // Request dropped mid-ACCESS still completes; a request arriving during ACK waits.
    req_a = 4'b0010;
    tick();
    tick();
    req_a = '0;
    check("drop_ioa", 64'(ioa_a[17:16]), 64'h1);
    tick();
    check("drop_ack", 64'(ack_a), 64'b0010);
    req_a = 4'b1000;
    tick();
    check("late_idle_busy", 64'(busy_a), 64'h0);
    check("late_idle_ack", 64'(ack_a), 64'h0);
    tick();
    check("late_g3", 64'(ioa_a[17:16]), 64'h3);
    tick();
    check("late_ack", 64'(ack_a), 64'b1000);
    req_a = '0;
    tick();

    // Three wait states: a read to seed rdata[1], then a write that must not touch it.
    req_b = 4'b0010; addr_b[16 +: 16] = 16'h1234; iodout_b = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("ws_rd_busy", 64'(busy_b), 64'h1);
      check("ws_rd_iowe", 64'(iowe_b), 64'h0);
    end
    tick();
    check("ws_rd_ack", 64'(ack_b), 64'b0010);
    check("ws_rd_rdata", 64'(rdata_b[15:8]), 64'h77);
    req_b = '0;
    tick();

    req_b = 4'b0010; we_b = 4'b0010; addr_b[16 +: 16] = 16'hBC00; din_b[15:8] = 8'h2A;
    iodout_b = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("ws_wr_ioa", 64'(ioa_b), 64'h1BC00);
      check("ws_wr_iodin", 64'(iodin_b), 64'h2A);
      check("ws_wr_iowe", 64'(iowe_b), (k == 4) ? 64'h1 : 64'h0);
      check("ws_wr_ack", 64'(ack_b), 64'h0);
    end
    tick();
    check("ws_wr_ack5", 64'(ack_b), 64'b0010);
    check("ws_wr_iowe_off", 64'(iowe_b), 64'h0);
    check("ws_wr_rdata", 64'(rdata_b[15:8]), 64'h77);
    req_b = '0; we_b = '0;
    tick();

    // Reset in the middle of a pending write.
    req_b = 4'b0001; we_b = 4'b0001; addr_b[15:0] = 16'hC0DE; din_b[7:0] = 8'h55;
    tick();
    tick();
    check("mid_busy", 64'(busy_b), 64'h1);
    rst_b = 1'b0;
    #1;
    check_b_idle("mid_async");
    check("mid_rdata", 64'(rdata_b), 64'h0);
    tick();
    check_b_idle("mid_hold1");
    req_b = '0; we_b = '0;
    tick();
    check_b_idle("mid_hold2");
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_iowe", 64'(iowe_b), 64'h0);
      check("post_ack", 64'(ack_b), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
